// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder (with full_adder leaf cell)
// Brief    : WIDTH-bit ripple adder split into STAGES registered slices with
//            valid/ready flow control on both sides.
// Revision : 1.0
// ============================================================================

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic             c_in_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_out_o,
    output logic             valid_o,
    input  logic             ready_i
);
    localparam int SW = WIDTH / STAGES;

    // Stage registers: operands are kept shifted down so the next slice to add
    // always sits in the low SW bits.
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [WIDTH-1:0]  r_op1 [STAGES];
    logic [WIDTH-1:0]  r_op2 [STAGES];

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_carry_nxt;
    logic [WIDTH-1:0]  w_sum_nxt [STAGES];
    logic [WIDTH-1:0]  w_op1_nxt [STAGES];
    logic [WIDTH-1:0]  w_op2_nxt [STAGES];

    // A stage may load when it is empty or its occupant leaves this cycle.
    always_comb begin
        w_adv = '0;
        w_adv[STAGES-1] = ~r_valid[STAGES-1] | ready_i;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = ~r_valid[k] | w_adv[k+1];
        end
    end

    always_comb begin
        w_load = '0;
        w_load[0] = valid_i & w_adv[0];
        for (int k = 1; k < STAGES; k++) begin
            w_load[k] = r_valid[k-1] & w_adv[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_src1;
        logic [WIDTH-1:0] w_src2;
        logic [WIDTH-1:0] w_base;
        logic [WIDTH-1:0] w_sum_ins;
        logic [SW-1:0]    w_slice;
        logic             w_cin;

        if (k == 0) begin : g_head
            assign w_src1 = op1_i;
            assign w_src2 = op2_i;
            assign w_cin  = c_in_i;
            assign w_base = '0;
        end else begin : g_body
            assign w_src1 = r_op1[k-1];
            assign w_src2 = r_op2[k-1];
            assign w_cin  = r_carry[k-1];
            assign w_base = r_sum[k-1];
        end

        for (genvar b = 0; b < SW; b++) begin : g_bit
            logic w_ci;
            logic w_co;
            if (b == 0) begin : g_lsb
                assign w_ci = w_cin;
            end else begin : g_chain
                assign w_ci = g_bit[b-1].w_co;
            end
            full_adder u_fa (
                .i_a (w_src1[b]),
                .i_b (w_src2[b]),
                .i_c (w_ci),
                .o_s (w_slice[b]),
                .o_c (w_co)
            );
        end

        always_comb begin
            w_sum_ins = w_base;
            w_sum_ins[k*SW +: SW] = w_slice;
        end

        assign w_sum_nxt[k]   = w_sum_ins;
        assign w_carry_nxt[k] = g_bit[SW-1].w_co;
        assign w_op1_nxt[k]   = w_src1 >> SW;
        assign w_op2_nxt[k]   = w_src2 >> SW;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_valid <= '0;
            r_carry <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_sum[k] <= '0;
                r_op1[k] <= '0;
                r_op2[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= w_load[k];
                    if (w_load[k]) begin
                        r_sum[k]   <= w_sum_nxt[k];
                        r_carry[k] <= w_carry_nxt[k];
                        r_op1[k]   <= w_op1_nxt[k];
                        r_op2[k]   <= w_op2_nxt[k];
                    end
                end
            end
        end
    end

    assign ready_o = w_adv[0];
    assign valid_o = r_valid[STAGES-1];
    assign sum_o   = r_sum[STAGES-1];
    assign c_out_o = r_carry[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Brief    : Directed self-checking bench for pipelined_adder (64 bit, 4 stages).
// Revision : 1.0
// ============================================================================

module tb_pipelined_adder;
    logic        clk_i;
    logic        arst_ni;
    logic [63:0] op1_i;
    logic [63:0] op2_i;
    logic        c_in_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] sum_o;
    logic        c_out_o;
    logic        valid_o;
    logic        ready_i;

    int checks = 0;
    int errors = 0;

    pipelined_adder #(
        .WIDTH  (64),
        .STAGES (4)
    ) u_dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .op1_i   (op1_i),
        .op2_i   (op2_i),
        .c_in_i  (c_in_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sum_o   (sum_o),
        .c_out_o (c_out_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #22;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_o); end
        checks++; if (sum_o !== 64'd0) begin errors++; $display("FAIL rst_sum got %h want 0", sum_o); end
        checks++; if (c_out_o !== 1'b0) begin errors++; $display("FAIL rst_cout got %b want 0", c_out_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready_o); end
        arst_ni = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", ready_o); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid_after got %b want 0", valid_o); end
    endtask

    task automatic test_vectors();
        logic [63:0] t_a   [4];
        logic [63:0] t_b   [4];
        logic        t_ci  [4];
        logic [63:0] t_sum [4];
        logic        t_co  [4];
        int lat;
        t_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[0] = 64'd1; t_ci[0] = 1'b0;
        t_sum[0] = 64'd0; t_co[0] = 1'b1;
        t_a[1] = 64'h0000_FFFF_FFFF_FFFF; t_b[1] = 64'd0; t_ci[1] = 1'b1;
        t_sum[1] = 64'h0001_0000_0000_0000; t_co[1] = 1'b0;
        t_a[2] = 64'h8000_0000_0000_0000; t_b[2] = 64'h8000_0000_0000_0000; t_ci[2] = 1'b1;
        t_sum[2] = 64'd1; t_co[2] = 1'b1;
        t_a[3] = 64'h0123_4567_89AB_CDEF; t_b[3] = 64'hFEDC_BA98_7654_3210; t_ci[3] = 1'b0;
        t_sum[3] = 64'hFFFF_FFFF_FFFF_FFFF; t_co[3] = 1'b0;
        ready_i = 1'b1;
        for (int v = 0; v < 4; v++) begin
            op1_i = t_a[v]; op2_i = t_b[v]; c_in_i = t_ci[v]; valid_i = 1'b1;
            #1;
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL vec%0d_ready got %b want 1", v, ready_o); end
            tick();
            valid_i = 1'b0;
            lat = 0;
            while (valid_o !== 1'b1 && lat < 10) begin
                tick();
                lat++;
            end
            // Three edges after the accepting edge: result visible in the 4th cycle.
            checks++; if (lat != 3) begin errors++; $display("FAIL vec%0d_latency got %0d want 3", v, lat); end
            checks++; if (sum_o !== t_sum[v]) begin errors++; $display("FAIL vec%0d_sum got %h want %h", v, sum_o, t_sum[v]); end
            checks++; if (c_out_o !== t_co[v]) begin errors++; $display("FAIL vec%0d_cout got %b want %b", v, c_out_o, t_co[v]); end
            tick();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL vec%0d_one_cycle got %b want 0", v, valid_o); end
        end
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        for (int t = 0; t < 14; t++) begin
            if (t < 8) begin
                op1_i = 64'(t + 1); op2_i = 64'(t + 1); c_in_i = 1'b0; valid_i = 1'b1;
                #1;
                checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready t=%0d got %b want 1", t, ready_o); end
            end else begin
                valid_i = 1'b0;
            end
            tick();
            if (t >= 3 && t <= 10) begin
                checks++;
                if (valid_o !== 1'b1 || sum_o !== 64'(2 * (t - 2)) || c_out_o !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_out t=%0d got v=%b s=%0d c=%b want v=1 s=%0d c=0", t, valid_o, sum_o, c_out_o, 2 * (t - 2));
                end
            end else begin
                checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle t=%0d got %b want 0", t, valid_o); end
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            op1_i = 64'd1000 + 64'((c < 4) ? c : 4);
            op2_i = 64'hFFFF_FFFF_FFFF_FF00; c_in_i = 1'b1; valid_i = 1'b1;
            #1;
            checks++; if (ready_o !== (c < 4)) begin errors++; $display("FAIL bp_fill c=%0d got %b want %b", c, ready_o, (c < 4)); end
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (ready_o !== 1'b0 || valid_o !== 1'b1 || sum_o !== 64'd745 || c_out_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c=%0d got r=%b v=%b s=%0d c=%b want r=0 v=1 s=745 c=1", c, ready_o, valid_o, sum_o, c_out_o);
            end
            tick();
        end
        valid_i = 1'b0; ready_i = 1'b1;
        got = 0;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (valid_o === 1'b1) begin
                checks++;
                if (sum_o !== 64'd745 + 64'(got) || c_out_o !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_drain%0d got s=%0d c=%b want s=%0d c=1", got, sum_o, c_out_o, 745 + got);
                end
                got++;
            end
            tick();
        end
        checks++; if (got != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got); end
    endtask

    task automatic test_flow_pattern();
        logic [64:0] exp_q[$];
        logic [64:0] exp;
        logic [63:0] a;
        logic [63:0] b;
        for (int cyc = 0; cyc < 80; cyc++) begin
            a = 64'h9E37_79B9_7F4A_7C15 * 64'(cyc + 1);
            b = ~(a << 3);
            op1_i = a; op2_i = b; c_in_i = cyc[0];
            valid_i = (cyc % 5 != 2) && (cyc < 60);
            ready_i = (cyc % 4 != 3) && !(cyc >= 20 && cyc < 27);
            #1;
            if (valid_o === 1'b1 && ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL flow_extra cyc=%0d got s=%h want no result", cyc, sum_o);
                end else begin
                    exp = exp_q.pop_front();
                    if ({c_out_o, sum_o} !== exp) begin
                        errors++;
                        $display("FAIL flow_result cyc=%0d got %h want %h", cyc, {c_out_o, sum_o}, exp);
                    end
                end
            end
            if (valid_i && ready_o === 1'b1) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + 65'(c_in_i));
            end
            tick();
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flow_leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        int stale;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op1_i = 64'(16 + i); op2_i = 64'h20; c_in_i = 1'b0; valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        tick();
        checks++;
        if (valid_o !== 1'b1 || sum_o !== 64'h30) begin
            errors++;
            $display("FAIL mid_pre got v=%b s=%h want v=1 s=30", valid_o, sum_o);
        end
        #1 arst_ni = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", valid_o); end
        checks++; if (sum_o !== 64'd0 || c_out_o !== 1'b0) begin errors++; $display("FAIL mid_data got s=%h c=%b want 0", sum_o, c_out_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", ready_o); end
        #4 arst_ni = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid_o !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale got %0d want 0", stale); end
    endtask

    initial begin
        arst_ni = 1'b0;
        op1_i = '0; op2_i = '0; c_in_i = 1'b0;
        valid_i = 1'b0; ready_i = 1'b1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_flow_pattern();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the operand and sum width in bits.
REQ-002 The module SHALL have parameter STAGES, default 4, giving the number of pipeline stages; WIDTH SHALL be divisible by STAGES, and SW = WIDTH/STAGES is the slice width.
REQ-003 Port clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-004 Port arst_ni  input  1  asynchronous active-low reset.
REQ-005 Port op1_i  input  WIDTH  operand 1.
REQ-006 Port op2_i  input  WIDTH  operand 2.
REQ-007 Port c_in_i  input  1  carry in to bit 0.
REQ-008 Port valid_i  input  1  upstream offers an operand set.
REQ-009 Port ready_o  output  1  block can accept an operand set this cycle.
REQ-010 Port sum_o  output  WIDTH  result, op1 + op2 + c_in modulo 2^WIDTH.
REQ-011 Port c_out_o  output  1  carry out of bit WIDTH-1.
REQ-012 Port valid_o  output  1  sum_o and c_out_o hold a valid result.
REQ-013 Port ready_i  input  1  downstream accepts the result this cycle.

Function
REQ-014 A transfer SHALL occur on each edge where valid_i=1 and ready_o=1; an output transfer SHALL occur on each edge where valid_o=1 and ready_i=1.
REQ-015 Stage k (0..STAGES-1) SHALL add slice bits [k*SW +: SW] using a ripple chain of full_adder instances, one per bit, with carry in from stage k-1 (stage 0: c_in_i).
REQ-016 Each stage register SHALL hold: valid bit, completed sum bits below the slice boundary, the slice carry out, and the operand bits not yet added.
REQ-017 Stage 0 SHALL load on an input transfer; stage k>0 SHALL load from stage k-1 when stage k-1 is valid and stage k advances.
REQ-018 Stage k SHALL advance (be free to load) when it is invalid or its contents move on in the same cycle; the last stage moves on when ready_i=1.
REQ-019 ready_o SHALL equal (stage 0 invalid) OR (stage 0 advancing), with no combinational path from valid_i to ready_o.
REQ-020 A stage that does not advance SHALL hold its contents unchanged; a stage emptied without refill SHALL clear its valid bit.
REQ-021 valid_o, sum_o and c_out_o SHALL be driven directly from the last stage register.
REQ-022 Latency SHALL be exactly STAGES cycles from input transfer to valid_o with ready_i held high; throughput SHALL be one result per cycle.
REQ-023 Results SHALL leave in acceptance order, with no loss or duplication under any valid_i/ready_i pattern.
REQ-024 When valid_o=1 and ready_i=0, sum_o, c_out_o and valid_o SHALL remain stable until transfer.
REQ-025 Simultaneous input and output transfers with all stages full SHALL be accepted without a bubble.
REQ-026 Overflow SHALL wrap modulo 2^WIDTH with the carry reported on c_out_o; there are no error flags.

Reset
REQ-027 While arst_ni=0, all stage valid bits SHALL be 0, valid_o=0, sum_o=0 and c_out_o=0, independent of clk_i.
REQ-028 ready_o SHALL be 1 during reset and immediately after deassertion.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight results; no stale valid_o SHALL appear after deassertion.

Verification
REQ-030 Defaults, ready_i=1: op1=0xFFFF_FFFF_FFFF_FFFF, op2=1, c_in=0 -> after 4 cycles sum_o=0, c_out_o=1, valid_o=1 for one cycle.
REQ-031 Carry crossing every slice: op1=0x0000_FFFF_FFFF_FFFF, op2=0, c_in=1 -> sum_o=0x0001_0000_0000_0000, c_out_o=0.
REQ-032 Back-to-back: 8 consecutive transfers of op1=i, op2=i, c_in=0, i=1..8 -> sum_o 2,4,...,16 on 8 consecutive cycles, starting 4 cycles after the first transfer.
REQ-033 Backpressure: fill with 4 operand sets, hold ready_i=0 for 10 cycles -> ready_o=0 after 4 accepts, outputs stable; release -> all 4 results drain in order.
REQ-034 Reset mid-stream: 3 operand sets in flight, pulse arst_ni low for half a cycle -> valid_o=0 immediately, and no result appears afterwards without new input.
REQ-035 Random: 10^5 transfers with random operands and random valid_i/ready_i -> each result equals the reference op1+op2+c_in, in order.
